// File: rtl/conv_seq_ctrl.sv
// Convolution + max-pool sequencer: walks a KxK kernel over the image one pooled window at a time.
// Optional CONV_CTRL_PERF_EN adds busy-cycle and output-stall counters.
module conv_seq_ctrl #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int POOL    = 2,
  parameter int ADDR_W  = 6,
  parameter int WADDR_W = 4,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pool_ready,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               mac_en,
  output logic               mac_first,
  output logic               mac_last,
  output logic               conv_vld,
  output logic               pool_first,
  output logic               pool_last,
  output logic               pool_vld,
  output logic [IDX_W-1:0]   pool_idx,
  output logic               busy,
  output logic               done
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [15:0]        cyc_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one kernel tap address issued per cycle
  // DRAIN | 3 cycles for the MAC / pool pipeline to settle
  // OUT   | pooled result presented, waiting for pool_ready
  // DONE  | one-cycle frame-complete pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int NPC = (IMG_W - K + 1) / POOL;
  localparam int NPR = (IMG_H - K + 1) / POOL;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int CCW = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int CRW = (NPR > 1) ? $clog2(NPR) : 1;
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  logic [2:0]     state;
  logic [CW-1:0]  kx, ky;
  logic [PW-1:0]  px, py;
  logic [CCW-1:0] pcol;
  logic [CRW-1:0] prow;
  logic [1:0]     drain_cnt;
  logic           pix_first_d, pix_last_d;

  logic kx_end, ky_end, px_end, py_end, pcol_end, prow_end;
  logic tap_last, win_last, frame_last, run;

  assign kx_end     = (kx == CW'(K - 1));
  assign ky_end     = (ky == CW'(K - 1));
  assign px_end     = (px == PW'(POOL - 1));
  assign py_end     = (py == PW'(POOL - 1));
  assign pcol_end   = (pcol == CCW'(NPC - 1));
  assign prow_end   = (prow == CRW'(NPR - 1));
  assign tap_last   = kx_end && ky_end;
  assign win_last   = tap_last && px_end && py_end;
  assign frame_last = pcol_end && prow_end;
  assign run        = (state == S_RUN);

  // Addresses follow the counters, which are frozen outside RUN so the RAM ports hold.
  assign img_addr = (ADDR_W'(prow) * ADDR_W'(POOL) + ADDR_W'(py) + ADDR_W'(ky)) * ADDR_W'(IMG_W)
                  + ADDR_W'(pcol) * ADDR_W'(POOL) + ADDR_W'(px) + ADDR_W'(kx);
  assign wgt_addr = WADDR_W'(ky) * WADDR_W'(K) + WADDR_W'(kx);

  assign pool_vld = (state == S_OUT);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      kx        <= '0;
      ky        <= '0;
      px        <= '0;
      py        <= '0;
      pcol      <= '0;
      prow      <= '0;
      drain_cnt <= '0;
      pool_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            kx       <= '0;
            ky       <= '0;
            px       <= '0;
            py       <= '0;
            pcol     <= '0;
            prow     <= '0;
            pool_idx <= '0;
          end
        end
        S_RUN: begin
          if (win_last) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else if (!kx_end) begin
            kx <= kx + 1'b1;
          end else begin
            kx <= '0;
            if (!ky_end) begin
              ky <= ky + 1'b1;
            end else begin
              ky <= '0;
              if (!px_end) begin
                px <= px + 1'b1;
              end else begin
                px <= '0;
                py <= py + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= S_OUT;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        S_OUT: begin
          if (pool_ready) begin
            if (frame_last) begin
              state <= S_DONE;
            end else begin
              state    <= S_RUN;
              kx       <= '0;
              ky       <= '0;
              px       <= '0;
              py       <= '0;
              pool_idx <= pool_idx + 1'b1;
              if (!pcol_end) begin
                pcol <= pcol + 1'b1;
              end else begin
                pcol <= '0;
                prow <= prow + 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes trail the address issue: MAC sees RAM data one cycle later, conv sum one more.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_en      <= 1'b0;
      mac_first   <= 1'b0;
      mac_last    <= 1'b0;
      pix_first_d <= 1'b0;
      pix_last_d  <= 1'b0;
      conv_vld    <= 1'b0;
      pool_first  <= 1'b0;
      pool_last   <= 1'b0;
    end else begin
      mac_en      <= run;
      mac_first   <= run && (kx == '0) && (ky == '0);
      mac_last    <= run && tap_last;
      pix_first_d <= run && tap_last && (px == '0) && (py == '0);
      pix_last_d  <= run && win_last;
      conv_vld    <= mac_last;
      pool_first  <= pix_first_d;
      pool_last   <= pix_last_d;
    end
  end

`ifdef CONV_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        cyc_cnt   <= '0;
        stall_cnt <= '0;
      end
    end else begin
      if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
      if (state == S_OUT && !pool_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
